// File: rtl/impulse_sequencer_pkg.sv
// Shared types and widths for the impulse sequencer: FSM states, DMA_SPI
// parameter field widths and the effective-period helper.
package seq_pkg;
  localparam int TIME_W        = 64;
  localparam int FREQ_W        = 48;
  localparam int INT_W         = 32;
  localparam int NIMP_W        = 16;
  localparam int TYPE_W        = 8;
  localparam int TYPE_CONT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

  // A zero period behaves as a one-tick period so the phase counter always wraps.
  function automatic logic [INT_W-1:0] eff_period(input logic [INT_W-1:0] tp);
    return (tp == '0) ? INT_W'(1) : tp;
  endfunction
endpackage

// File: rtl/impulse_sequencer_imp_gate_gen.sv
// Impulse and receiver-blank gates, registered from the next-cycle phase so
// they line up with the phase counter with no extra lag.
module imp_gate_gen
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [INT_W-1:0] p_i,
  input  logic [INT_W-1:0] ti_i,
  input  logic [INT_W-1:0] tblank1_i,
  input  logic [INT_W-1:0] tblank2_i,
  output logic             imp_o,
  output logic             blank_o
);
  logic [INT_W:0] blank2_end;
  logic           imp_d, blank_d, imp_q, blank_q;

  // Trailing-blank end is widened so Ti + Tblank2 never wraps.
  assign blank2_end = {1'b0, ti_i} + {1'b0, tblank2_i};
  assign imp_d      = run_i && (p_i < ti_i);
  assign blank_d    = run_i && ((p_i < tblank1_i) ||
                                ((p_i >= ti_i) && ({1'b0, p_i} < blank2_end)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imp_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      imp_q   <= imp_d;
      blank_q <= blank_d;
    end
  end

  assign imp_o   = imp_q;
  assign blank_o = blank_q;
endmodule

// File: rtl/impulse_sequencer.sv
// Radar impulse train sequencer: system time base, parameter shadowing on
// SPI_WR, armed start at TIME_START, period/phase counting and NCO stepping.
module impulse_sequencer
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [TIME_W-1:0] TIME,
  input  logic              SYS_TIME_UPDATE,
  input  logic              SPI_WR,
  input  logic [FREQ_W-1:0] FREQ,
  input  logic [FREQ_W-1:0] FREQ_STEP,
  input  logic [INT_W-1:0]  FREQ_RATE,
  input  logic [TIME_W-1:0] TIME_START,
  input  logic [NIMP_W-1:0] N_impulse,
  input  logic [TYPE_W-1:0] TYPE_impulse,
  input  logic [INT_W-1:0]  Interval_Ti,
  input  logic [INT_W-1:0]  Interval_Tp,
  input  logic [INT_W-1:0]  Tblank1,
  input  logic [INT_W-1:0]  Tblank2,
  output logic [TIME_W-1:0] SYS_TIME,
  output logic              IMP,
  output logic              BLANK,
  output logic              FRAME_START,
  output logic [FREQ_W-1:0] FREQ_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              LATE
);
  seq_state_e        state_q;
  logic [TIME_W-1:0] sys_time_q, tstart_q;
  logic [FREQ_W-1:0] freq_q, step_q, freq_out_q;
  logic [INT_W-1:0]  rate_q, ti_q, tp_q, tb1_q, tb2_q, p_q, p_d, rate_cnt_q, tp_eff;
  logic [NIMP_W-1:0] n_q, periods_q;
  logic              cont_q, fs_q, done_q, busy_q, late_q;
  logic              start_hit, tick_run, period_end, last_period, zero_run, step_now;
  logic              gate_run_d;
  logic              unused_type_bits;

  assign unused_type_bits = ^TYPE_impulse[TYPE_W-1:1];

  assign tp_eff      = eff_period(tp_q);
  assign start_hit   = (state_q == ARMED) && clk_en && (sys_time_q >= tstart_q);
  assign tick_run    = (state_q == RUN) && clk_en;
  assign period_end  = tick_run && (p_q == tp_eff - INT_W'(1));
  assign last_period = !cont_q && (({1'b0, periods_q} + 17'd1) == {1'b0, n_q});
  assign zero_run    = !cont_q && (n_q == '0);
  assign step_now    = ({1'b0, rate_cnt_q} + 33'd1) == {1'b0, rate_q};

  // Next phase and gate-activity feed the gate generator so gates and p move together.
  always_comb begin
    p_d        = p_q;
    gate_run_d = (state_q == RUN);
    if (SPI_WR) begin
      p_d        = '0;
      gate_run_d = 1'b0;
    end else if (start_hit) begin
      p_d        = '0;
      gate_run_d = !zero_run;
    end else if (period_end) begin
      p_d        = '0;
      gate_run_d = !last_period;
    end else if (tick_run) begin
      p_d        = p_q + INT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_time_q <= '0;
    end else if (SYS_TIME_UPDATE) begin
      sys_time_q <= TIME;
    end else if (clk_en) begin
      sys_time_q <= sys_time_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tstart_q   <= '0;
      freq_q     <= '0;
      step_q     <= '0;
      rate_q     <= '0;
      n_q        <= '0;
      cont_q     <= 1'b0;
      ti_q       <= '0;
      tp_q       <= '0;
      tb1_q      <= '0;
      tb2_q      <= '0;
      p_q        <= '0;
      periods_q  <= '0;
      rate_cnt_q <= '0;
      freq_out_q <= '0;
      fs_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      fs_q   <= 1'b0;
      done_q <= 1'b0;
      p_q    <= p_d;
      if (SPI_WR) begin
        tstart_q <= TIME_START;
        freq_q   <= FREQ;
        step_q   <= FREQ_STEP;
        rate_q   <= FREQ_RATE;
        n_q      <= N_impulse;
        cont_q   <= TYPE_impulse[TYPE_CONT_BIT];
        ti_q     <= Interval_Ti;
        tp_q     <= Interval_Tp;
        tb1_q    <= Tblank1;
        tb2_q    <= Tblank2;
        late_q   <= 1'b0;
        busy_q   <= 1'b1;
        state_q  <= ARMED;
      end else begin
        case (state_q)
          ARMED: begin
            if (start_hit) begin
              if (sys_time_q > tstart_q) late_q <= 1'b1;
              if (zero_run) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q    <= RUN;
                fs_q       <= 1'b1;
                periods_q  <= '0;
                rate_cnt_q <= '0;
                freq_out_q <= freq_q;
              end
            end
          end
          RUN: begin
            if (period_end) begin
              if (last_period) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                fs_q      <= 1'b1;
                periods_q <= periods_q + NIMP_W'(1);
                // FREQ_RATE of zero disables stepping entirely.
                if (rate_q != '0) begin
                  if (step_now) begin
                    freq_out_q <= freq_out_q + step_q;
                    rate_cnt_q <= '0;
                  end else begin
                    rate_cnt_q <= rate_cnt_q + INT_W'(1);
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  imp_gate_gen u_gate (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (gate_run_d),
    .p_i       (p_d),
    .ti_i      (ti_q),
    .tblank1_i (tb1_q),
    .tblank2_i (tb2_q),
    .imp_o     (IMP),
    .blank_o   (BLANK)
  );

  assign SYS_TIME    = sys_time_q;
  assign FRAME_START = fs_q;
  assign FREQ_OUT    = freq_out_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign LATE        = late_q;
endmodule

// File: tb/tb_impulse_sequencer.sv
// Directed bench for impulse_sequencer: timing of frames, gates, DONE, LATE,
// frequency stepping, abort, continuous mode and asynchronous reset.
module tb_impulse_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, SYS_TIME_UPDATE, SPI_WR;
  logic [63:0] TIME, TIME_START, SYS_TIME;
  logic [47:0] FREQ, FREQ_STEP, FREQ_OUT;
  logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic [15:0] N_impulse;
  logic [7:0]  TYPE_impulse;
  logic        IMP, BLANK, FRAME_START, BUSY, DONE, LATE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit en_mode = 1'b0;
  bit en_prev;
  longint m_ti, m_tb1, m_tb2;
  int fs_cnt, done_cnt, done_cyc, imp_hi;
  int fs_cyc [0:15];
  logic [47:0] fs_freq [0:15];
  logic [63:0] fs_time0;
  logic late_fs0;

  always #5 clk = ~clk;

  impulse_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .TIME(TIME),
    .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .SPI_WR(SPI_WR), .FREQ(FREQ),
    .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
    .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .SYS_TIME(SYS_TIME), .IMP(IMP), .BLANK(BLANK), .FRAME_START(FRAME_START),
    .FREQ_OUT(FREQ_OUT), .BUSY(BUSY), .DONE(DONE), .LATE(LATE)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    en_prev = clk_en;
    @(posedge clk);
    #1;
    cyc++;
    clk_en = en_mode ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic spi_write(input logic [63:0] ts, input logic [15:0] n, input logic [7:0] typ,
                           input logic [31:0] tp, input logic [31:0] ti, input logic [31:0] tb1,
                           input logic [31:0] tb2, input logic [47:0] fr, input logic [47:0] st,
                           input logic [31:0] rate, input bit load, input logic [63:0] ld);
    TIME_START = ts; N_impulse = n; TYPE_impulse = typ; Interval_Tp = tp;
    Interval_Ti = ti; Tblank1 = tb1; Tblank2 = tb2; FREQ = fr; FREQ_STEP = st;
    FREQ_RATE = rate; SYS_TIME_UPDATE = load; TIME = ld; SPI_WR = 1'b1;
    m_ti = longint'(ti); m_tb1 = longint'(tb1); m_tb2 = longint'(tb2);
    $display("txn spi_wr start=%0d n=%0d type=%0h tp=%0d ti=%0d tb1=%0d tb2=%0d rate=%0d",
             ts, n, typ, tp, ti, tb1, tb2, rate);
    tick();
    SPI_WR = 1'b0;
    SYS_TIME_UPDATE = 1'b0;
  endtask

  // Follows the train from FRAME_START/DONE and checks each cycle's gates.
  task automatic monitor(input int maxc, input bit stop_done);
    bit in_run;
    longint p;
    in_run = 1'b0; p = 0;
    fs_cnt = 0; done_cnt = 0; done_cyc = -1; imp_hi = 0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (FRAME_START) begin
        if (fs_cnt < 16) begin
          fs_cyc[fs_cnt] = c;
          fs_freq[fs_cnt] = FREQ_OUT;
        end
        if (fs_cnt == 0) begin
          fs_time0 = SYS_TIME;
          late_fs0 = LATE;
        end
        fs_cnt++;
        in_run = 1'b1;
        p = 0;
      end else if (in_run && en_prev) begin
        p++;
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = c;
        in_run = 1'b0;
      end
      check("imp", IMP, in_run && (p < m_ti));
      check("blank", BLANK, in_run && ((p < m_tb1) || (p >= m_ti && p < m_ti + m_tb2)));
      if (IMP) imp_hi++;
      if (stop_done && DONE) break;
    end
    $display("txn monitor cycles<=%0d frames=%0d done=%0d", maxc, fs_cnt, done_cnt);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; SYS_TIME_UPDATE = 1'b0; SPI_WR = 1'b0; TIME = '0;
    TIME_START = '0; FREQ = '0; FREQ_STEP = '0; FREQ_RATE = '0; N_impulse = '0;
    TYPE_impulse = '0; Interval_Ti = '0; Interval_Tp = '0; Tblank1 = '0; Tblank2 = '0;
    m_ti = 0; m_tb1 = 0; m_tb2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sys_time", SYS_TIME, 64'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_freq_out", FREQ_OUT, 48'd0);
    check("rst_gates", {IMP, BLANK, FRAME_START, DONE, LATE}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic train: N=3, Tp=10, Ti=4, Tblank1=2, Tblank2=1 starting at time 100
    SYS_TIME_UPDATE = 1'b1; TIME = 64'd0;
    tick();
    SYS_TIME_UPDATE = 1'b0;
    check("t1_load", SYS_TIME, 64'd0);
    spi_write(64'd100, 16'd3, 8'd0, 32'd10, 32'd4, 32'd2, 32'd1, 48'd0, 48'd0, 32'd0, 1'b0, 64'd0);
    check("t1_sys_inc", SYS_TIME, 64'd1);
    check("t1_busy", BUSY, 1'b1);
    monitor(200, 1'b1);
    check("t1_fs_cnt", fs_cnt, 3);
    check("t1_first_fs", fs_cyc[0], 99);
    check("t1_fs_time", fs_time0, 64'd101);
    check("t1_gap1", fs_cyc[1] - fs_cyc[0], 10);
    check("t1_gap2", fs_cyc[2] - fs_cyc[1], 10);
    check("t1_done", done_cyc - fs_cyc[0], 30);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_late", LATE, 1'b0);
    check("t1_busy_end", BUSY, 1'b0);

    // Frequency stepping every 2 periods over 5 periods
    spi_write(64'd2, 16'd5, 8'd0, 32'd4, 32'd1, 32'd0, 32'd0, 48'h280000000000, 48'h2cbd3f,
              32'd2, 1'b1, 64'd0);
    monitor(40, 1'b1);
    check("t2_fs_cnt", fs_cnt, 5);
    check("t2_f0", fs_freq[0], 48'h280000000000);
    check("t2_f1", fs_freq[1], 48'h280000000000);
    check("t2_f2", fs_freq[2], 48'h2800002cbd3f);
    check("t2_f3", fs_freq[3], 48'h2800002cbd3f);
    check("t2_f4", fs_freq[4], 48'h280000597a7e);
    check("t2_hold", FREQ_OUT, 48'h280000597a7e);

    // Late start: TIME_START=50 with SYS_TIME already 200
    SYS_TIME_UPDATE = 1'b1; TIME = 64'd200;
    tick();
    SYS_TIME_UPDATE = 1'b0;
    spi_write(64'd50, 16'd1, 8'd0, 32'd3, 32'd1, 32'd0, 32'd0, 48'd5, 48'd0, 32'd0, 1'b0, 64'd0);
    monitor(20, 1'b1);
    check("t3_immediate", fs_cyc[0], 0);
    check("t3_fs_time", fs_time0, 64'd202);
    check("t3_late_at_fs", late_fs0, 1'b1);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_late_sticky", LATE, 1'b1);
    spi_write(64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 8'd0, 32'd3, 32'd1, 32'd0, 32'd0, 48'd0, 48'd0,
              32'd0, 1'b0, 64'd0);
    check("t3_late_clear", LATE, 1'b0);

    // Abort during the third period, then a new single-period train at 1100
    spi_write(64'd1005, 16'd5, 8'd0, 32'd10, 32'd4, 32'd2, 32'd1, 48'd0, 48'd0, 32'd0,
              1'b1, 64'd1000);
    monitor(28, 1'b0);
    check("t4_pre_fs", fs_cnt, 3);
    check("t4_pre_done", done_cnt, 0);
    check("t4_pre_time", fs_time0, 64'd1006);
    check("t4_pre_imp", IMP, 1'b1);
    spi_write(64'd1100, 16'd1, 8'd0, 32'd4, 32'd2, 32'd0, 32'd0, 48'd0, 48'd0, 32'd0, 1'b0, 64'd0);
    check("t4_abort_gates", {IMP, BLANK, FRAME_START, DONE}, 4'd0);
    check("t4_abort_busy", BUSY, 1'b1);
    monitor(150, 1'b1);
    check("t4_new_fs", fs_cnt, 1);
    check("t4_new_done", done_cnt, 1);
    check("t4_new_time", fs_time0, 64'd1101);
    check("t4_new_len", done_cyc - fs_cyc[0], 4);

    // N=0: DONE at the start condition without any frame
    spi_write(64'd3, 16'd0, 8'd0, 32'd4, 32'd2, 32'd1, 32'd1, 48'd0, 48'd0, 32'd0, 1'b1, 64'd0);
    monitor(20, 1'b1);
    check("t5_fs", fs_cnt, 0);
    check("t5_done", done_cnt, 1);
    check("t5_done_cyc", done_cyc, 3);
    check("t5_busy", BUSY, 1'b0);

    // Ti beyond the period: IMP high through the whole run
    spi_write(64'd3, 16'd2, 8'd0, 32'd10, 32'd20, 32'd0, 32'd0, 48'd0, 48'd0, 32'd0, 1'b1, 64'd0);
    monitor(40, 1'b1);
    check("t6_imp_hi", imp_hi, 20);
    check("t6_done", done_cnt, 1);

    // Continuous mode keeps framing past N
    spi_write(64'd3, 16'd2, 8'd1, 32'd5, 32'd1, 32'd0, 32'd0, 48'd0, 48'd0, 32'd0, 1'b1, 64'd0);
    monitor(40, 1'b0);
    check("t7_fs", fs_cnt, 8);
    check("t7_no_done", done_cnt, 0);
    check("t7_busy", BUSY, 1'b1);

    // clk_en 1-in-3, then asynchronous reset mid-run
    en_mode = 1'b1;
    spi_write(64'd2, 16'd3, 8'd0, 32'd4, 32'd2, 32'd1, 32'd1, 48'h1234, 48'd0, 32'd0,
              1'b1, 64'd0);
    monitor(40, 1'b0);
    check("t8_fs", fs_cnt, 3);
    check("t8_gap", fs_cyc[1] - fs_cyc[0], 12);
    check("t8_busy", BUSY, 1'b1);
    check("t8_freq", FREQ_OUT, 48'h1234);
    #3;
    rst_n = 1'b0;
    #1;
    check("t8_rst_sys", SYS_TIME, 64'd0);
    check("t8_rst_freq", FREQ_OUT, 48'd0);
    check("t8_rst_flags", {IMP, BLANK, FRAME_START, BUSY, DONE, LATE}, 6'd0);
    en_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("t8_stay_idle", BUSY, 1'b0);
    check("t8_sys_run", SYS_TIME, 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
